// File: rtl/product_accumulator_if.sv
// Handshake and result bundle between the upstream 4x4 multiplier stream,
// the run controller, and the product accumulator.
interface product_accumulator_if #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 5
) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic [7:0]       R;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc;
    logic             busy;
    logic             done;
    logic             ovf;

    // Producer / controller side: drives run control and products.
    modport master (
        output start, len, R, in_valid,
        input  in_ready, acc, busy, done, ovf
    );

    // Accumulator side.
    modport slave (
        input  start, len, R, in_valid,
        output in_ready, acc, busy, done, ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Product accumulator: sums a run of 'len' unsigned 8-bit products into a
// saturating ACC_W-bit accumulator, one product per cycle, with a sticky
// overflow flag and a one-cycle done pulse at the end of each run.
module product_accumulator #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 5
) (
    input logic                 clk,
    input logic                 rst,
    product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [LEN_W-1:0] remaining;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;

    logic             xfer;
    logic [ACC_W:0]   sum_p0;

    // Zero-extended add that clamps to all ones; MSB of the result flags
    // that clamping happened. A saturated accumulator stays saturated
    // because any further add either overflows again or adds zero.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       r);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W-7){1'b0}}, r};
        if (s[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = s;
        end
    endfunction

    // in_ready is a registered flag, so the transfer decision has no
    // combinational dependence of in_ready on in_valid.
    assign xfer   = bus.in_valid && in_ready_q;
    assign sum_p0 = sat_add(acc_q, bus.R);

    // Run controller and accumulator; outputs are registered alongside state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            remaining  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                        if (bus.len != '0) begin
                            remaining  <= bus.len;
                            state      <= ACCUM;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            // Empty run: report completion without accepting data.
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc_q     <= sum_p0[ACC_W-1:0];
                        remaining <= remaining - LEN_W'(1);
                        if (sum_p0[ACC_W]) begin
                            ovf_q <= 1'b1;
                        end
                        if (remaining == LEN_W'(1)) begin
                            state      <= DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.acc      = acc_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a per-cycle vector table for the
// basic, stall, zero-length, ignored-input and mid-run-reset runs, plus a
// hand-written saturation run.
module tb_product_accumulator;
    localparam int ACC_W = 12;
    localparam int LEN_W = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    product_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic             rst;
        logic             start;
        logic [LEN_W-1:0] len;
        logic [7:0]       r;
        logic             vld;
        logic [ACC_W-1:0] e_acc;
        logic             e_ovf;
        logic             e_busy;
        logic             e_done;
        logic             e_rdy;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic rs, input logic st, input int ln,
                                input int r, input logic v, input int ea,
                                input logic eo, input logic eb, input logic ed,
                                input logic er);
        vec_t t;
        t.rst = rs; t.start = st; t.len = LEN_W'(ln); t.r = 8'(r); t.vld = v;
        t.e_acc = ACC_W'(ea); t.e_ovf = eo; t.e_busy = eb; t.e_done = ed;
        t.e_rdy = er;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic st, input int ln,
                         input int r, input logic v);
        rst          = rs;
        bus.start    = st;
        bus.len      = LEN_W'(ln);
        bus.R        = 8'(r);
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int ea, input logic eo,
                           input logic eb, input logic ed, input logic er);
        chk({tag, ".acc"},      int'(bus.acc),      ea);
        chk({tag, ".ovf"},      int'(bus.ovf),      int'(eo));
        chk({tag, ".busy"},     int'(bus.busy),     int'(eb));
        chk({tag, ".done"},     int'(bus.done),     int'(ed));
        chk({tag, ".in_ready"}, int'(bus.in_ready), int'(er));
    endtask

    initial begin
        //                 rst st len  R    vld  acc    ovf busy done rdy
        tbl[0]  = mk(1, 0, 0, 8'h00, 0, 12'h000, 0, 0, 0, 0); // reset
        tbl[1]  = mk(0, 0, 0, 8'h55, 1, 12'h000, 0, 0, 0, 0); // R ignored in IDLE
        tbl[2]  = mk(0, 1, 3, 8'h00, 0, 12'h000, 0, 1, 0, 1); // basic run len=3
        tbl[3]  = mk(0, 0, 0, 8'h00, 1, 12'h000, 0, 1, 0, 1);
        tbl[4]  = mk(0, 0, 0, 8'h32, 1, 12'h032, 0, 1, 0, 1);
        tbl[5]  = mk(0, 0, 0, 8'h36, 1, 12'h068, 0, 0, 1, 0); // done pulse
        tbl[6]  = mk(0, 0, 0, 8'h00, 0, 12'h068, 0, 0, 0, 0); // back to IDLE, hold
        tbl[7]  = mk(0, 0, 0, 8'hFF, 1, 12'h068, 0, 0, 0, 0); // R ignored in IDLE
        tbl[8]  = mk(0, 1, 2, 8'h00, 0, 12'h000, 0, 1, 0, 1); // stall run len=2
        tbl[9]  = mk(0, 0, 0, 8'hE1, 1, 12'h0E1, 0, 1, 0, 1);
        tbl[10] = mk(0, 0, 0, 8'hFF, 0, 12'h0E1, 0, 1, 0, 1); // stall
        tbl[11] = mk(0, 1, 7, 8'hFF, 0, 12'h0E1, 0, 1, 0, 1); // stall + start ignored
        tbl[12] = mk(0, 0, 0, 8'hE1, 1, 12'h1C2, 0, 0, 1, 0); // 2nd transfer ends run
        tbl[13] = mk(0, 1, 1, 8'h11, 1, 12'h1C2, 0, 0, 0, 0); // start ignored in DONE
        tbl[14] = mk(0, 1, 0, 8'h22, 1, 12'h000, 0, 0, 1, 0); // zero length
        tbl[15] = mk(0, 0, 0, 8'h22, 1, 12'h000, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 4, 8'h00, 0, 12'h000, 0, 1, 0, 1); // len=4, then reset
        tbl[17] = mk(0, 0, 0, 8'h10, 1, 12'h010, 0, 1, 0, 1);
        tbl[18] = mk(0, 0, 0, 8'h20, 1, 12'h030, 0, 1, 0, 1);
        tbl[19] = mk(1, 1, 3, 8'h40, 1, 12'h000, 0, 0, 0, 0); // rst wins
        tbl[20] = mk(0, 0, 0, 8'h40, 1, 12'h000, 0, 0, 0, 0); // no done pulse
        tbl[21] = mk(0, 1, 1, 8'h00, 0, 12'h000, 0, 1, 0, 1);
        tbl[22] = mk(0, 0, 0, 8'h05, 1, 12'h005, 0, 0, 1, 0);
        tbl[23] = mk(0, 0, 0, 8'h00, 0, 12'h005, 0, 0, 0, 0);

        rst = 1'b1; bus.start = 1'b0; bus.len = '0; bus.R = '0; bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].start, int'(tbl[i].len), int'(tbl[i].r), tbl[i].vld);
            chk_all($sformatf("vec%0d", i), int'(tbl[i].e_acc), tbl[i].e_ovf,
                    tbl[i].e_busy, tbl[i].e_done, tbl[i].e_rdy);
        end

        // Saturation: 31 x 0xE1. 18 x 225 = 4050 fits, the 19th overflows.
        drive(0, 1, 31, 0, 0);
        chk_all("sat.start", 0, 0, 1, 0, 1);
        for (int k = 1; k <= 31; k++) begin
            drive(0, 0, 0, 8'hE1, 1);
            if (k == 18) chk_all("sat.t18", 12'hFD2, 0, 1, 0, 1);
            if (k == 19) chk_all("sat.t19", 12'hFFF, 1, 1, 0, 1);
            if (k == 25) chk_all("sat.t25", 12'hFFF, 1, 1, 0, 1);
            if (k == 30) chk_all("sat.t30", 12'hFFF, 1, 1, 0, 1);
            if (k == 31) chk_all("sat.t31", 12'hFFF, 1, 0, 1, 0);
        end
        drive(0, 0, 0, 0, 0);
        chk_all("sat.idle", 12'hFFF, 1, 0, 0, 0);
        drive(0, 1, 2, 0, 0);
        chk_all("sat.restart", 0, 0, 1, 0, 1);
        drive(0, 0, 0, 8'h01, 1);
        drive(0, 0, 0, 8'h02, 1);
        chk_all("sat.rerun", 3, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        chk_all("sat.rerun_idle", 3, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the run never reaches the summary.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter ACC_W, default 12: accumulator width in bits, minimum 9.
REQ-002 Parameter LEN_W, default 5: width of the term-count input.
REQ-003 Port clk, input, 1: single clock; all state updates occur on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port start, input, 1: begin a new accumulation run; accepted only in IDLE.
REQ-006 Port len, input, LEN_W: number of products in the run; sampled when start is accepted.
REQ-007 Port R, input, 8: unsigned product from the upstream 4x4 multiplier.
REQ-008 Port in_valid, input, 1: R holds a valid product this cycle.
REQ-009 Port in_ready, output, 1: block accepts R this cycle.
REQ-010 Port acc, output, ACC_W: running or final sum.
REQ-011 Port busy, output, 1: high while in ACCUM.
REQ-012 Port done, output, 1: one-cycle pulse when a run completes.
REQ-013 Port ovf, output, 1: sticky saturation flag for the current or last run.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and DONE, and SHALL be encoded in registers.
REQ-015 In IDLE with start=1 and len!=0, the block SHALL clear acc and ovf, load remaining=len, and enter ACCUM on the next edge.
REQ-016 In IDLE with start=1 and len=0, the block SHALL clear acc and ovf, enter DONE directly, and accept no products.
REQ-017 In IDLE, start=0 SHALL hold all state; acc and ovf SHALL keep the last run's result.
REQ-018 in_ready SHALL be high only in ACCUM; it SHALL be a registered-state decode with no combinational path from in_valid.
REQ-019 A transfer SHALL occur when in_valid=1 and in_ready=1 on a rising edge.
REQ-020 On each transfer, acc SHALL update to acc+R, zero-extended, with the new value visible the cycle after the edge (1-cycle latency), and remaining SHALL decrement by 1.
REQ-021 If acc+R exceeds 2^ACC_W-1, acc SHALL saturate to all ones and ovf SHALL set.
REQ-022 ovf SHALL stay set until the next accepted start or until reset.
REQ-023 Once acc is saturated, further transfers SHALL keep acc at all ones.
REQ-024 A transfer that brings remaining to 0 SHALL move the FSM to DONE.
REQ-025 In ACCUM, cycles with in_valid=0 SHALL hold acc and remaining unchanged; there SHALL be no timeout.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 start SHALL be ignored in ACCUM and DONE.
REQ-028 A new start SHALL be accepted no earlier than the cycle after DONE.
REQ-029 busy SHALL equal (state==ACCUM).
REQ-030 done SHALL equal (state==DONE).
REQ-031 R SHALL be ignored when no transfer occurs, including when in_valid=1 in IDLE or DONE.
REQ-032 Back-to-back transfers on consecutive cycles SHALL be supported at one product per cycle.

Reset
REQ-033 When rst=1 on a rising edge, the block SHALL set state=IDLE, acc=0, ovf=0, remaining=0, in_ready=0, busy=0 and done=0.
REQ-034 rst SHALL take priority over start and over any transfer in the same cycle.
REQ-035 rst asserted mid-run (ACCUM) SHALL abort the run with no done pulse; the discarded partial sum SHALL not reappear.

Verification
REQ-036 Basic run: reset, start with len=3, products 0x00, 0x32 and 0x36 on consecutive cycles -> acc=0x068, done pulses one cycle after the third transfer, ovf=0.
REQ-037 Stalls: len=2, in_valid toggled 1,0,0,1 with R=0xE1 both transfers -> acc=0x1C2, busy high for 4 cycles, single done pulse.
REQ-038 Saturation: ACC_W=12, len=31, R=0xE1 every cycle -> acc saturates at 0xFFF after the 19th transfer, ovf=1, done after the 31st transfer; next start clears ovf.
REQ-039 Zero length: start with len=0 -> done the next cycle, acc=0, in_ready never high.
REQ-040 Mid-run reset: len=4, rst asserted after 2 transfers -> all outputs return to reset values next cycle, no done pulse; a following len=1 run with R=0x05 yields acc=0x005.
REQ-041 Ignored inputs: start asserted during ACCUM and in_valid asserted in IDLE -> no change to remaining, acc or state.
